wb_arbiter: RTL and testbench

Writeback arbiter in front of the register file's single write port. Merges the in-order pipeline writeback (MEM/WB) with results from the long-latency multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained into free writeback slots. A 31-bit pending-register scoreboard lets the hazard logic stall on operands whose MDU result has not yet been written.

---
 rtl/wb_arbiter_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter slice.
// Register index, data, source select and FIFO entry definitions.
package wb_arbiter_pkg;

  typedef logic [4:0]  reg_ind_t;
  typedef logic [63:0] data_t;

  localparam int MDU_BUF_DEPTH    = 2;
  localparam int MDU_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_MDU_BUF,
    WB_MDU_BYP
  } wb_src_t;

  typedef struct packed {
    reg_ind_t rd;
    data_t    data;
  } wb_ent_t;

  function automatic logic is_live(
    input reg_ind_t r
  );
    return r != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding MDU results awaiting a free slot.
// Depth is a power of two so pointers wrap naturally.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = MDU_BUF_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_ent_t push_ent,
  input  logic    pop,
  output wb_ent_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(BUF_DEPTH);

  wb_ent_t        mem [BUF_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline first, then buffered
// or bypassed MDU results, with a pending-register scoreboard.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH    = MDU_BUF_DEPTH,
  parameter int STARVE_LIMIT = MDU_STARVE_LIMIT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pipe_we,
  input  reg_ind_t pipe_rd,
  input  data_t    pipe_wdata,
  input  logic     mdu_valid,
  output logic     mdu_ready,
  input  reg_ind_t mdu_rd,
  input  data_t    mdu_data,
  input  logic     iss_valid,
  input  reg_ind_t iss_rd,
  input  reg_ind_t chk_rs1,
  input  reg_ind_t chk_rs2,
  input  reg_ind_t chk_rd,
  output logic     busy_rs1,
  output logic     busy_rs2,
  output logic     busy_rd,
  output logic     stall_req,
  output logic     rf_we,
  output reg_ind_t rf_waddr,
  output data_t    rf_wdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  wb_src_t        src;
  wb_ent_t        head;
  wb_ent_t        mdu_ent;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           pipe_hit;
  logic           mdu_live;
  logic           mdu_fire;
  logic [31:0]    sb;
  logic [31:0]    sb_set;
  logic [31:0]    sb_clr;
  logic [CW-1:0]  starve_cnt;

  assign pipe_hit = pipe_we && is_live(pipe_rd);
  assign mdu_live = mdu_valid && is_live(mdu_rd);
  assign mdu_ent  = '{rd: mdu_rd, data: mdu_data};

  assign mdu_ready = !rst && !fifo_full;
  assign mdu_fire  = mdu_valid && mdu_ready;

  always_comb begin
    src = WB_NONE;
    priority case (1'b1)
      rst:                     src = WB_NONE;
      pipe_hit:                src = WB_PIPE;
      !fifo_empty:             src = WB_MDU_BUF;
      fifo_empty && mdu_live:  src = WB_MDU_BYP;
      default:                 src = WB_NONE;
    endcase
  end

  always_comb begin
    rf_we    = src != WB_NONE;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (src)
      WB_PIPE: begin
        rf_waddr = pipe_rd;
        rf_wdata = pipe_wdata;
      end
      WB_MDU_BUF: begin
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
      WB_MDU_BYP: begin
        rf_waddr = mdu_rd;
        rf_wdata = mdu_data;
      end
      default: begin
        rf_waddr = '0;
        rf_wdata = '0;
      end
    endcase
  end

  // x0 results are accepted but never stored; bypassed ones skip the FIFO
  assign pop  = src == WB_MDU_BUF;
  assign push = mdu_fire && is_live(mdu_rd) && (src != WB_MDU_BYP);

  wb_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_ent (mdu_ent),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (iss_valid) begin
      sb_set[iss_rd] = 1'b1;
    end
    if (src == WB_MDU_BUF) begin
      sb_clr[head.rd] = 1'b1;
    end
    if (src == WB_MDU_BYP) begin
      sb_clr[mdu_rd] = 1'b1;
    end
  end

  // set is OR-ed in after the clear so a same-cycle reissue stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb <= ((sb & ~sb_clr) | sb_set) & ~32'h1;
    end
  end

  assign busy_rs1 = !rst && sb[chk_rs1];
  assign busy_rs2 = !rst && sb[chk_rs2];
  assign busy_rd  = !rst && sb[chk_rd];

  always_ff @(posedge clk) begin
    if (rst || fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign stall_req = !rst && (starve_cnt == LIMIT);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed steps plus random
// traffic, compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_wdata;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        busy_rd;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  bit   [31:0] msb;
  int   mst;

  wb_arbiter #(
    .BUF_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_rd    (pipe_rd),
    .pipe_wdata (pipe_wdata),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_rd     (mdu_rd),
    .mdu_data   (mdu_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .busy_rs1   (busy_rs1),
    .busy_rs2   (busy_rs2),
    .busy_rd    (busy_rd),
    .stall_req  (stall_req),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    bit   ph, e_we, e_rdy, pop, byp;
    logic [4:0]  e_a;
    logic [63:0] e_d;
    ent_t hd;
    ph    = pipe_we && pipe_rd != 0;
    e_rdy = !rst && q.size() < DEPTH;
    e_we  = 1'b0;
    e_a   = '0;
    e_d   = '0;
    pop   = 1'b0;
    byp   = 1'b0;
    if (!rst) begin
      if (ph) begin
        e_we = 1'b1; e_a = pipe_rd; e_d = pipe_wdata;
      end else if (q.size() > 0) begin
        hd = q[0];
        e_we = 1'b1; e_a = hd.rd; e_d = hd.d; pop = 1'b1;
      end else if (mdu_valid && mdu_rd != 0) begin
        e_we = 1'b1; e_a = mdu_rd; e_d = mdu_data; byp = 1'b1;
      end
    end
    #1;
    chk("mdu_ready", 64'(mdu_ready), 64'(e_rdy));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    if (e_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(e_a));
      chk("rf_wdata", rf_wdata, e_d);
    end
    chk("stall_req", 64'(stall_req), 64'(!rst && mst == LIMIT));
    chk("busy_rs1", 64'(busy_rs1), 64'(!rst && msb[chk_rs1]));
    chk("busy_rs2", 64'(busy_rs2), 64'(!rst && msb[chk_rs2]));
    chk("busy_rd", 64'(busy_rd), 64'(!rst && msb[chk_rd]));
    @(posedge clk);
    if (rst) begin
      q.delete();
      msb = '0;
      mst = 0;
    end else begin
      if (q.size() == 0 || pop) mst = 0;
      else if (mst < LIMIT) mst++;
      if (pop) msb[e_a] = 1'b0;
      if (byp) msb[mdu_rd] = 1'b0;
      if (iss_valid && iss_rd != 0) msb[iss_rd] = 1'b1;
      if (pop) void'(q.pop_front());
      if (e_rdy && mdu_valid && mdu_rd != 0 && !byp)
        q.push_back('{rd: mdu_rd, d: mdu_data});
    end
    @(negedge clk);
  endtask

  task automatic go(input bit r, input bit pw, input logic [4:0] prd,
                    input logic [63:0] pd, input bit mv,
                    input logic [4:0] mrd, input logic [63:0] md,
                    input bit iv, input logic [4:0] ird,
                    input logic [4:0] c1, input logic [4:0] c2,
                    input logic [4:0] c3);
    rst = r; pipe_we = pw; pipe_rd = prd; pipe_wdata = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    iss_valid = iv; iss_rd = ird;
    chk_rs1 = c1; chk_rs2 = c2; chk_rd = c3;
    cyc();
  endtask

  initial begin
    msb = '0;
    mst = 0;
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    go(1, 1, 3, 1, 1, 4, 2, 1, 5, 5, 4, 3);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3);
    // pipe and MDU collide: pipe first, MDU next cycle
    go(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    go(0, 1, 5, 64'h11, 1, 7, 64'h22, 0, 0, 7, 5, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    // bypass with empty FIFO
    go(0, 0, 0, 0, 1, 9, 64'h33, 0, 0, 9, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    // starvation under continuous pipeline writes
    go(0, 0, 0, 0, 0, 0, 0, 1, 10, 10, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 1, 11, 10, 11, 0);
    for (int i = 0; i < 7; i++)
      go(0, 1, 3, 64'(i), i < 2, 5'(10 + i), 64'(8'hA0 + i), 0, 0,
         10, 11, 3);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0);
    go(0, 1, 3, 64'h77, 0, 0, 0, 0, 0, 10, 11, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0);
    // x0 pipeline write leaves the slot to the FIFO head
    go(0, 1, 3, 64'h1, 1, 4, 64'h44, 1, 4, 4, 0, 0);
    go(0, 1, 0, 64'hdead, 0, 0, 0, 0, 0, 4, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
    // reissue of x12 in the same cycle its old result commits
    go(0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 0, 0);
    go(0, 0, 0, 0, 1, 12, 64'h55, 1, 12, 12, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 1, 0, 12, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0);
    // reset with two entries queued
    go(0, 1, 3, 64'h1, 1, 20, 64'h1, 1, 20, 20, 0, 0);
    go(0, 1, 3, 64'h2, 1, 21, 64'h2, 1, 21, 20, 21, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 12);
    go(0, 0, 0, 0, 1, 22, 64'h3, 0, 0, 20, 21, 12);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 22);
    for (int i = 0; i < 400; i++) begin
      go($urandom_range(0, 59) == 0,
         $urandom_range(0, 2) != 0,
         5'($urandom_range(0, 31)),
         {$urandom, $urandom},
         $urandom_range(0, 1) == 1,
         5'($urandom_range(0, 31)),
         {$urandom, $urandom},
         $urandom_range(0, 3) == 0,
         5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
